// File: rtl/fp_accum_seq.sv
// Run-length sequencer that folds a stream of FP32 operands into one total
// through an external combinational FP32 adder, then hands the total out on a valid/ready port.
module fp_accum_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             neg_seen
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    r_len_q;
  logic [CNT_W-1:0]    w_len_nxt;
  logic                r_neg;
  logic                w_neg_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                w_accept;
  logic                w_last;

  assign w_accept = (r_state == S_ACC) && in_valid;
  assign w_last   = (r_cnt == (r_len_q - CNT_W'(1)));

  // State register and per-run datapath registers; handshake flags are
  // registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len_q     <= w_len_nxt;
      r_neg       <= w_neg_nxt;
      r_in_ready  <= (w_state_nxt == S_ACC);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len_q;
    w_neg_nxt   = r_neg;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt = len;
          w_cnt_nxt = '0;
          w_neg_nxt = 1'b0;
          if (len == '0) begin
            w_acc_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACC;
          end
        end
      end

      S_ACC: begin
        if (w_accept) begin
          // The first operand seeds the sum directly; later ones take the adder result.
          w_acc_nxt = (r_cnt == '0) ? in_data : add_sum;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_neg_nxt = r_neg | in_data[DATA_W-1];
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign add_a     = r_acc;
  assign add_b     = in_data;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign busy      = r_busy;
  assign neg_seen  = r_neg;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: a real-arithmetic FP32 adder stands in for FpAdd, and a
// scoreboard holds the expected total of every run until the output handshake pops it.
module tb_fp_accum_seq;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  logic             neg_seen;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid_cycles = 0;
  logic [31:0] q_data[$];
  logic        q_neg[$];
  logic [31:0] ops_q[$];

  always #5 clk = ~clk;

  fp_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .neg_seen  (neg_seen)
  );

  // FP32 <-> double conversion for normal numbers; zero/denormal inputs read as zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    logic        g;
    logic        s;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]};
    g = d[28];
    s = |d[27:0];
    if (g && (s || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  always_comb add_sum = fp_add(add_a, add_b);

  function automatic logic [31:0] rnd_op(input bit allow_neg);
    logic s;
    s = allow_neg && ($urandom_range(0, 7) == 0);
    return {s, 8'($urandom_range(124, 131)), 23'($urandom)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake retires the oldest expected total.
  always @(negedge clk) begin
    if (out_valid) n_valid_cycles++;
    if (out_valid && out_ready) begin
      if (q_data.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_total: got %h with empty scoreboard", out_data);
      end else begin
        chk("total", out_data, q_data.pop_front());
        chk1("neg_seen_at_out", neg_seen, q_neg.pop_front());
      end
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    len   = n;
    @(posedge clk); #1;
    start = 1'b0;
    len   = CNT_W'($urandom);
  endtask

  // One complete run over ops_q; use_const replaces the model total with a known constant.
  task automatic run(input int gap_max, input bit fixed_gap, input int ready_dly,
                     input bit use_const, input logic [31:0] exp_const);
    logic [31:0] exp_sum;
    logic [31:0] part;
    logic        exp_neg;
    int          n;
    int          gap;
    n       = ops_q.size();
    exp_sum = 32'd0;
    exp_neg = 1'b0;
    foreach (ops_q[i]) begin
      exp_sum = (i == 0) ? ops_q[i] : fp_add(exp_sum, ops_q[i]);
      exp_neg = exp_neg | ops_q[i][31];
    end
    if (use_const) exp_sum = exp_const;
    q_data.push_back(exp_sum);
    q_neg.push_back(exp_neg);

    do_start(CNT_W'(n));
    @(negedge clk);
    chk1("in_ready_after_start", in_ready, n != 0);
    chk1("busy_after_start", busy, 1'b1);
    chk1("neg_clear_at_start", neg_seen, 1'b0);

    part = 32'd0;
    for (int i = 0; i < n; i++) begin
      gap = fixed_gap ? gap_max : int'($urandom_range(0, gap_max));
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk); #1;
        if (i > 0) chk("acc_hold_gap", add_a, part);
        chk("add_b_follows_in", add_b, in_data);
        chk1("no_valid_mid_run", out_valid, 1'b0);
      end
      in_valid = 1'b1;
      in_data  = ops_q[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      part = (i == 0) ? ops_q[i] : fp_add(part, ops_q[i]);
      chk("acc_after_accept", add_a, part);
      chk1("out_valid_after_accept", out_valid, i == n - 1);
    end

    if (n == 0) begin
      @(posedge clk); #1;
      chk1("len0_done", out_valid, 1'b1);
      chk1("len0_in_ready", in_ready, 1'b0);
    end

    repeat (ready_dly) begin
      @(posedge clk); #1;
      chk1("valid_held", out_valid, 1'b1);
      chk("data_held", out_data, exp_sum);
      chk1("in_ready_in_done", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_valid", out_valid, 1'b0);
    chk1("idle_in_ready", in_ready, 1'b0);
  endtask

  task automatic reset_abort();
    int v0;
    do_start(CNT_W'(4));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    @(posedge clk); #1;
    in_data  = 32'hC0400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("neg_before_abort", neg_seen, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v0 = n_valid_cycles;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b0);
    chk1("abort_valid", out_valid, 1'b0);
    chk1("abort_neg", neg_seen, 1'b0);
    chk("abort_acc", add_a, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    repeat (6) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("idle_ignores_input", add_a, 32'd0);
    chk("no_valid_after_abort", 32'(n_valid_cycles), 32'(v0));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_neg_seen", neg_seen, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_acc", add_a, 32'd0);

    ops_q = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run(0, 1'b1, 0, 1'b1, 32'h40800000);

    ops_q = {32'h3F800000, 32'h40000000, 32'h40400000};
    run(2, 1'b1, 0, 1'b1, 32'h40C00000);

    ops_q = {32'h41360000, 32'h40B2041B};
    run(0, 1'b1, 1, 1'b0, 32'd0);

    ops_q.delete();
    run(0, 1'b1, 5, 1'b1, 32'd0);

    ops_q = {32'h41360000, 32'hC0B2041B};
    run(1, 1'b0, 2, 1'b0, 32'd0);

    ops_q = {32'h3F800000, 32'h40000000};
    run(0, 1'b1, 0, 1'b1, 32'h40400000);

    reset_abort();
    ops_q = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run(0, 1'b1, 0, 1'b1, 32'h40800000);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = int'($urandom_range(0, 8));
      ops_q.delete();
      for (int k = 0; k < n; k++) ops_q.push_back(rnd_op(1'b1));
      run(2, 1'b0, int'($urandom_range(0, 3)), 1'b0, 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q_data.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
